// File: rtl/mem_req_rr_arbiter.sv
// Round-robin arbiter sharing one memory request port among NumReq requesters,
// with an in-order ID FIFO that routes each response back to its issuer.
module mem_req_rr_arbiter #(
  parameter  int NumReq         = 4,
  parameter  int AddrWidth      = 32,
  parameter  int DataWidth      = 64,
  parameter  int MaxOutstanding = 4,
  localparam int StrbWidth      = DataWidth / 8,
  localparam int IdxWidth       = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CntWidth       = $clog2(MaxOutstanding + 1),
  localparam int PtrWidth       = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq-1:0]             req_write_i,
  input  logic [NumReq*StrbWidth-1:0]   req_strb_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic                          mem_q_valid_o,
  output logic                          mem_q_write_o,
  output logic [StrbWidth-1:0]          mem_q_strb_o,
  output logic [AddrWidth-1:0]          mem_q_addr_o,
  output logic [DataWidth-1:0]          mem_q_data_o,
  input  logic                          mem_ready_i,
  input  logic                          mem_p_valid_i,
  input  logic [DataWidth-1:0]          mem_p_data_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]          rsp_data_o,
  output logic [CntWidth-1:0]           outstanding_o,
  output logic                          err_o
);

  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [PtrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [IdxWidth-1:0] idx_mem_q [MaxOutstanding];

  logic [IdxWidth-1:0] gnt_idx;
  logic                gnt_found;
  logic                full, hs, pop;
  int                  cand;

  // Scan from the priority pointer, wrapping modulo NumReq.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int off = 0; off < NumReq; off++) begin
      cand = (int'(rr_q) + off) % NumReq;
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxWidth'(cand);
      end
    end
  end

  // Full blocks requests even on a same-cycle pop, so ready never depends on the response path.
  assign full          = (cnt_q == CntWidth'(MaxOutstanding));
  assign mem_q_valid_o = rst_ni & gnt_found & ~full;
  assign hs            = mem_q_valid_o & mem_ready_i;
  assign pop           = mem_p_valid_i & (cnt_q != '0);

  always_comb begin
    mem_q_write_o = 1'b0;
    mem_q_strb_o  = '0;
    mem_q_addr_o  = '0;
    mem_q_data_o  = '0;
    req_ready_o   = '0;
    if (rst_ni && gnt_found) begin
      mem_q_write_o = req_write_i[gnt_idx];
      mem_q_strb_o  = req_strb_i[int'(gnt_idx)*StrbWidth +: StrbWidth];
      mem_q_addr_o  = req_addr_i[int'(gnt_idx)*AddrWidth +: AddrWidth];
      mem_q_data_o  = req_data_i[int'(gnt_idx)*DataWidth +: DataWidth];
    end
    if (hs) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid_o = '0;
    if (rst_ni && pop) rsp_valid_o[idx_mem_q[rptr_q]] = 1'b1;
  end

  assign rsp_data_o    = rst_ni ? mem_p_data_i : '0;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_comb begin
    rr_d   = rr_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    err_d  = err_q | (mem_p_valid_i & (cnt_q == '0));
    if (hs) begin
      rr_d   = (gnt_idx == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
      wptr_d = (wptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) rptr_d = (rptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
    if (hs && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!hs && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // ID storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (hs) idx_mem_q[wptr_q] <= gnt_idx;
  end

endmodule

// File: tb/tb_mem_req_rr_arbiter.sv
// Bench for mem_req_rr_arbiter: per-cycle vectors with a scoreboard of granted
// indices that predicts which requester each returned response belongs to.
module tb_mem_req_rr_arbiter;

  logic         clk;
  logic         rst_ni;
  logic [3:0]   req_valid, req_write, req_ready;
  logic [31:0]  req_strb;
  logic [127:0] req_addr;
  logic [255:0] req_data;
  logic         q_valid, q_write, mem_ready, p_valid, err;
  logic [7:0]   q_strb;
  logic [31:0]  q_addr;
  logic [63:0]  q_data, p_data, rsp_data;
  logic [3:0]   rsp_valid;
  logic [2:0]   outstanding;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];

  typedef struct {
    logic [3:0]  rv;
    logic        rdy;
    logic        pv;
    logic [63:0] pd;
    int          g;
    int          out;
  } vec_t;
  vec_t tbl[19];

  mem_req_rr_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_strb_i(req_strb),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_ready_o(req_ready),
    .mem_q_valid_o(q_valid), .mem_q_write_o(q_write), .mem_q_strb_o(q_strb),
    .mem_q_addr_o(q_addr), .mem_q_data_o(q_data), .mem_ready_i(mem_ready),
    .mem_p_valid_i(p_valid), .mem_p_data_i(p_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .outstanding_o(outstanding), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, update scoreboard, advance.
  task automatic apply(input logic [3:0] rv, input logic rdy, input logic pv,
                       input logic [63:0] pd, input int g, input int out);
    logic       qv;
    logic [3:0] er, ersp;
    int         h;
    req_valid = rv; mem_ready = rdy; p_valid = pv; p_data = pd;
    #1;
    qv = (rv != 4'b0) && (out < 4);
    er = (qv && rdy) ? 4'(1 << g) : 4'b0;
    chk("outstanding", outstanding, out);
    chk("q_valid", q_valid, qv);
    chk("req_ready", req_ready, er);
    if (rv == 4'b0)
      chk("payload_zero", {q_write, q_strb, q_addr, q_data}, 128'd0);
    else if (qv)
      chk("payload", {q_write, q_strb, q_addr, q_data},
          {(g % 2 == 1), 8'(1 << g), 32'h1000 + 32'(g), 64'hD000 + 64'(g)});
    ersp = 4'b0;
    if (pv && sb.size() > 0) begin
      h = sb.pop_front();
      ersp = 4'(1 << h);
    end
    chk("rsp_valid", rsp_valid, ersp);
    if (pv) chk("rsp_data", rsp_data, pd);
    if (er != 4'b0) sb.push_back(g);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_write[i]          = (i % 2 == 1);
      req_strb[i*8 +: 8]    = 8'(1 << i);
      req_addr[i*32 +: 32]  = 32'h1000 + 32'(i);
      req_data[i*64 +: 64]  = 64'hD000 + 64'(i);
    end
    // all four requesting, responses one cycle behind
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 64'h0,  0, 0};
    tbl[1]  = '{4'hF, 1'b1, 1'b1, 64'hA0, 1, 1};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 64'hA1, 2, 1};
    tbl[3]  = '{4'hF, 1'b1, 1'b1, 64'hA2, 3, 1};
    tbl[4]  = '{4'hF, 1'b1, 1'b1, 64'hA3, 0, 1};
    tbl[5]  = '{4'h0, 1'b0, 1'b1, 64'hA0, 0, 1};
    tbl[6]  = '{4'h0, 1'b0, 1'b0, 64'h0,  0, 0};
    // only req 2, fill to full, pop while full, then accepted
    tbl[7]  = '{4'h4, 1'b1, 1'b0, 64'h0,  2, 0};
    tbl[8]  = '{4'h4, 1'b1, 1'b0, 64'h0,  2, 1};
    tbl[9]  = '{4'h4, 1'b1, 1'b0, 64'h0,  2, 2};
    tbl[10] = '{4'h4, 1'b1, 1'b0, 64'h0,  2, 3};
    tbl[11] = '{4'h4, 1'b1, 1'b0, 64'h0,  2, 4};
    tbl[12] = '{4'h4, 1'b1, 1'b1, 64'hB0, 2, 4};
    tbl[13] = '{4'h4, 1'b1, 1'b0, 64'h0,  2, 3};
    tbl[14] = '{4'h0, 1'b0, 1'b1, 64'hB1, 0, 4};
    tbl[15] = '{4'h0, 1'b0, 1'b1, 64'hB2, 0, 3};
    tbl[16] = '{4'h0, 1'b0, 1'b1, 64'hB3, 0, 2};
    tbl[17] = '{4'h0, 1'b0, 1'b1, 64'hB4, 0, 1};
    tbl[18] = '{4'h0, 1'b0, 1'b0, 64'h0,  0, 0};

    rst_ni = 1'b0; req_valid = 4'b0; mem_ready = 1'b0; p_valid = 1'b0; p_data = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outstanding", outstanding, 0);
    chk("reset_err", err, 0);
    chk("reset_q_valid", q_valid, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 19; i++)
      apply(tbl[i].rv, tbl[i].rdy, tbl[i].pv, tbl[i].pd, tbl[i].g, tbl[i].out);

    // fresh reset so the pointer is 0, then stall with req 1 and 3
    rst_ni = 1'b0; #1;
    chk("reset2_outstanding", outstanding, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    sb.delete();
    repeat (3) apply(4'b1010, 1'b0, 1'b0, 64'h0, 1, 0);
    apply(4'b1010, 1'b1, 1'b0, 64'h0,  1, 0);
    apply(4'b1010, 1'b1, 1'b0, 64'h0,  3, 1);
    apply(4'b0000, 1'b0, 1'b1, 64'hA1, 0, 2);
    apply(4'b0000, 1'b0, 1'b1, 64'hA3, 0, 1);
    apply(4'b0000, 1'b0, 1'b0, 64'h0,  0, 0);

    // response with empty FIFO: sticky error, later responses still route
    chk("err_before", err, 0);
    apply(4'b0000, 1'b0, 1'b1, 64'h55, 0, 0);
    chk("err_raised", err, 1);
    apply(4'b0001, 1'b1, 1'b0, 64'h0,  0, 0);
    apply(4'b0000, 1'b0, 1'b1, 64'hC0, 0, 1);
    chk("err_sticky", err, 1);

    // simultaneous push of req 0 and pop of head 3 at occupancy 2
    apply(4'b1000, 1'b1, 1'b0, 64'h0,  3, 0);
    apply(4'b0100, 1'b1, 1'b0, 64'h0,  2, 1);
    apply(4'b0001, 1'b1, 1'b1, 64'hC3, 0, 2);
    apply(4'b0000, 1'b0, 1'b1, 64'hC2, 0, 2);
    apply(4'b0000, 1'b0, 1'b1, 64'hC0, 0, 1);
    apply(4'b0000, 1'b0, 1'b0, 64'h0,  0, 0);

    // asynchronous reset mid-burst at occupancy 3 with pointer at 1
    apply(4'hF,    1'b1, 1'b0, 64'h0, 1, 0);
    apply(4'hF,    1'b1, 1'b0, 64'h0, 2, 1);
    apply(4'b0001, 1'b1, 1'b0, 64'h0, 0, 2);
    req_valid = 4'hF; mem_ready = 1'b1; p_valid = 1'b1; p_data = 64'hEE;
    #1;
    chk("pre_rst_outstanding", outstanding, 3);
    chk("pre_rst_ready", req_ready, 4'b0010);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_q_valid", q_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    sb.delete();
    req_valid = 4'b0; p_valid = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    apply(4'hF,    1'b1, 1'b0, 64'h0,  0, 0);
    apply(4'hF,    1'b1, 1'b1, 64'hF0, 1, 1);
    apply(4'b0000, 1'b0, 1'b1, 64'hF1, 0, 1);
    apply(4'b0000, 1'b0, 1'b0, 64'h0,  0, 0);
    chk("post_rst_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_req_rr_arbiter.md
Name: mem_req_rr_arbiter

Overview:
- Shares one memory-island request port among NumReq requesters using round-robin arbitration.
- Routes in-order responses back to the issuing requester through an internal ID FIFO.
- Sits upstream of the request multicut / memory bank controller. Its output request port connects directly to a cut stage or bank.
- Every accepted request (read or write) produces exactly one response, in order.

Parameters:
- NumReq, 4, number of requesters (>=2).
- AddrWidth, 32, address width.
- DataWidth, 64, data width; StrbWidth = DataWidth/8 (derived, not overridable).
- MaxOutstanding, 4, depth of the response-routing FIFO (>=1).
- IdxWidth, derived: max(1, $clog2(NumReq)).
- CntWidth, derived: $clog2(MaxOutstanding+1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NumReq  per-requester request valid.
- req_write_i  in  NumReq  per-requester write enable.
- req_strb_i  in  NumReq x StrbWidth  byte strobes.
- req_addr_i  in  NumReq x AddrWidth  addresses.
- req_data_i  in  NumReq x DataWidth  write data.
- req_ready_o  out  NumReq  per-requester accept.
- mem_q_valid_o  out  1  request valid to memory.
- mem_q_write_o  out  1  selected write.
- mem_q_strb_o  out  StrbWidth  selected strobe.
- mem_q_addr_o  out  AddrWidth  selected address.
- mem_q_data_o  out  DataWidth  selected data.
- mem_ready_i  in  1  memory accepts request.
- mem_p_valid_i  in  1  response valid from memory, one per accepted request, in order.
- mem_p_data_i  in  DataWidth  response data.
- rsp_valid_o  out  NumReq  one-hot response valid to the owning requester.
- rsp_data_o  out  DataWidth  response data, broadcast to all requesters.
- outstanding_o  out  CntWidth  FIFO occupancy.
- err_o  out  1  sticky error: response arrived with FIFO empty.

Behaviour:
- Arbitration:
  - Combinational.
  - Priority pointer rr_q (IdxWidth bits, reset 0).
  - Grant goes to the first valid requester scanning rr_q, rr_q+1, ... with wrap modulo NumReq.
  - The grant is computed only when the FIFO is not full; when full, no grant is issued.
- Output request:
  - mem_q_valid_o = any req_valid_i AND NOT full.
  - Payload is muxed from the granted index. When no request is valid, the payload is all zeros.
- Ready:
  - req_ready_o[g] = mem_ready_i AND mem_q_valid_o, for the granted index g only.
  - All other req_ready_o bits are 0.
  - Ready depends combinationally on mem_ready_i. No combinational path runs from mem_ready_i to mem_q_valid_o.
- Handshake (mem_q_valid_o & mem_ready_i):
  - Push g into the FIFO.
  - rr_q <= (g+1) mod NumReq. When NumReq is not a power of two, wrap explicitly from NumReq-1 to 0.
  - Without a handshake, rr_q holds, even if valid is held while memory stalls.
  - The grant may change between cycles while mem_ready_i=0. Requesters keep their request stable until ready; the arbiter does not lock.
- Response:
  - When mem_p_valid_i=1 and the FIFO is non-empty: rsp_valid_o = onehot(head), rsp_data_o = mem_p_data_i, and head is popped.
  - Response latency through the block is 0 cycles (combinational).
- Response with an empty FIFO:
  - rsp_valid_o = 0.
  - err_o <= 1, remaining set until reset.
- FIFO full/empty:
  - Full when occupancy == MaxOutstanding.
  - When full, requests are blocked even if a pop occurs in the same cycle. This is a deliberate choice that removes the pop-to-ready path.
  - A push and a pop in the same cycle (not full, not empty) leave the occupancy unchanged.
  - Read and write pointers wrap modulo MaxOutstanding.
- Reset (asynchronous, any time including mid-transaction):
  - rr_q=0, FIFO empty, outstanding_o=0, err_o=0.
  - During reset: mem_q_valid_o=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0.
  - In-flight responses are forgotten. A response after reset raises err_o.
- Width rules: outstanding_o counts 0..MaxOutstanding without overflow. The idx stored in the FIFO is IdxWidth bits.

Test Plan:
- All 4 requesters valid, mem_ready_i=1, responses returned 1 cycle later -> grants in order 0,1,2,3,0,...; each rsp_valid_o is one-hot to the matching requester, and rsp_data_o equals the returned data (e.g. 0xA0+idx).
- Only req 2 valid for 5 cycles, mem_ready_i=1, MaxOutstanding=4, no responses -> 4 handshakes, then outstanding_o=4 and mem_q_valid_o=0; the 5th request is only accepted the cycle after one response pops.
- Req 1 and req 3 valid, mem_ready_i=0 for 3 cycles, then 1 -> rr_q stays 0 during the stall, req 1 is granted first, then rr_q=2 and req 3 is next.
- mem_p_valid_i=1 with an empty FIFO -> rsp_valid_o=0, err_o rises the next cycle and stays 1; a later valid response routes normally.
- Same-cycle handshake (req 0) and response (head=3) with occupancy 2 -> rsp_valid_o=4'b1000, occupancy stays 2, FIFO tail holds 0.
- rst_ni asserted asynchronously mid-burst with occupancy 3 -> all outputs are 0 immediately, outstanding_o=0; after release, grants start from req 0.
